// File: rtl/fmap_col_loader_pkg.sv
// Shared geometry for the conv accelerator feature-map loader.
// Column, channel and beat sizing used by every loader file.
package acc_pkg;

  localparam int HIT    = 56;
  localparam int WID    = 56;
  localparam int CHN    = 64;
  localparam int DW     = 32;
  localparam int BW     = 128;

  localparam int BEATS  = HIT * DW / BW;
  localparam int CDW    = HIT * DW;
  localparam int COL_W  = $clog2(WID);
  localparam int CH_W   = $clog2(CHN);
  localparam int BEAT_W = $clog2(BEATS);

  localparam bit BW_OK  = ((HIT * DW) % BW) == 0;

endpackage

// File: rtl/fmap_col_loader_col_bank.sv
// One column register bank of the ping-pong pair.
// Filled beat by beat, flagged full on the last beat, freed on drain.
module col_bank
  import acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] beat,
  input  logic [BW-1:0]     wr_data,
  input  logic              drain,
  output logic              full,
  output logic [CDW-1:0]    data
);

  logic last_beat;

  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (clr) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (wr_en) begin
        data[beat*BW +: BW] <= wr_data;
        if (last_beat)
          full <= 1'b1;
      end
      // fill and drain never hit the same bank
      if (drain)
        full <= 1'b0;
    end
  end

endmodule

// File: rtl/fmap_col_loader.sv
// Packs the 128-bit feature-map stream into 56-word columns.
// Ping-pong banks; tags columns with position and frame markers.
module fmap_col_loader
  import acc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BW-1:0]   s_data,
  output logic            col_valid,
  input  logic            col_ready,
  output logic [CDW-1:0]  col_data,
  output logic            col_first,
  output logic            col_last,
  output logic [CH_W-1:0] ch_idx,
  output logic            frame_done
);

  if (!BW_OK) begin : g_bw_chk
    $error("column width must be a multiple of beat width");
  end

  logic              wr_sel;
  logic              rd_sel;
  logic [BEAT_W-1:0] beat_cnt;
  logic [COL_W-1:0]  col_idx;
  logic [1:0]        full;
  logic [CDW-1:0]    bank_q [2];
  logic              acc;
  logic              hs;
  logic              beat_end;
  logic              col_end;
  logic              ch_end;

  assign s_ready   = ~full[wr_sel];
  assign acc       = s_valid & s_ready;
  assign col_valid = full[rd_sel];
  assign hs        = col_valid & col_ready;
  assign col_data  = bank_q[rd_sel];
  assign beat_end  = (beat_cnt == BEAT_W'(BEATS - 1));
  assign col_end   = (col_idx == COL_W'(WID - 1));
  assign ch_end    = (ch_idx == CH_W'(CHN - 1));
  assign col_first = (col_idx == '0);
  assign col_last  = col_end;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    col_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .wr_en   (acc & (wr_sel == 1'(i))),
      .beat    (beat_cnt),
      .wr_data (s_data),
      .drain   (hs & (rd_sel == 1'(i))),
      .full    (full[i]),
      .data    (bank_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel     <= 1'b0;
      beat_cnt   <= '0;
    end else if (clr) begin
      wr_sel     <= 1'b0;
      beat_cnt   <= '0;
    end else if (acc) begin
      beat_cnt <= beat_end ? '0 : beat_cnt + BEAT_W'(1);
      if (beat_end)
        wr_sel <= ~wr_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel     <= 1'b0;
      col_idx    <= '0;
      ch_idx     <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      rd_sel     <= 1'b0;
      col_idx    <= '0;
      ch_idx     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= hs & col_end & ch_end;
      if (hs) begin
        rd_sel  <= ~rd_sel;
        col_idx <= col_end ? '0 : col_idx + COL_W'(1);
        if (col_end)
          ch_idx <= ch_end ? '0 : ch_idx + CH_W'(1);
      end
    end
  end

endmodule
